cmp_bist: RTL and testbench



---
 rtl/cmp_bist_pkg.sv | 14 +
 rtl/cmp_bist_gt_ref_model.sv | 14 +
 rtl/cmp_bist.sv | 112 +++++++++++
 tb/tb_cmp_bist.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the comparator BIST engine: FSM state encoding and default sizing.
package cmp_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int W_DEF          = 4;
  localparam int SETTLE_CYC_DEF = 2;

endpackage

// File: rtl/cmp_bist_gt_ref_model.sv
// Golden unsigned a > b reference used by the BIST to form the expected gt value.
module gt_ref_model
  import cmp_bist_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule

// File: rtl/cmp_bist.sv
// Exhaustive self-test sweep for a W-bit magnitude comparator; counts mismatches, captures first failure.
// Optional build macro CMP_BIST_STOP_ON_FAIL_EN: halt at the first mismatching vector.
module cmp_bist
  import cmp_bist_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  input  logic           gt_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic [W-1:0]   fail_a,
  output logic [W-1:0]   fail_b
);

  localparam int             SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t          state;
  logic [2*W:0]    vec_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            exp_gt;
  logic            mism;
  logic            last_vec;

  assign a_out = vec_cnt[2*W-1:W];
  assign b_out = vec_cnt[W-1:0];

  gt_ref_model #(.W(W)) u_ref (
    .a  (a_out),
    .b  (b_out),
    .gt (exp_gt)
  );

  assign mism = (gt_in != exp_gt);
  // The extra top bit can never be set in normal operation; treating it as terminal keeps a stray count from running on.
  assign last_vec = (&vec_cnt[2*W-1:0]) | vec_cnt[2*W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            vec_cnt    <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mism) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) begin
              fail_a <= a_out;
              fail_b <= b_out;
            end
          end
`ifdef CMP_BIST_STOP_ON_FAIL_EN
          if (mism) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (last_vec) begin
`else
          if (last_vec) begin
`endif
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mism;
          end else begin
            vec_cnt <= vec_cnt + 1'b1;
            state   <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_bist.sv
// Directed bench for cmp_bist: healthy, stuck-at and single-fault comparators, reset and start handling.
module tb_cmp_bist;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_out, b_out;
  logic         gt_in;
  logic         busy, done, pass;
  logic [2*W:0] err_cnt;
  logic [W-1:0] fail_a, fail_b;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 healthy, 1 tied 0, 2 tied 1, 3 inverted at a=9 b=3
  int cyc;

  always #5 clk = ~clk;

  cmp_bist #(.W(W), .SETTLE_CYC(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_out   (a_out),
    .b_out   (b_out),
    .gt_in   (gt_in),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .fail_a  (fail_a),
    .fail_b  (fail_b)
  );

  always_comb begin
    gt_in = 1'b0;
    case (mode)
      0: gt_in = (a_out > b_out);
      1: gt_in = 1'b0;
      2: gt_in = 1'b1;
      3: gt_in = (a_out > b_out) ^ ((a_out == 4'd9) && (b_out == 4'd3));
      default: gt_in = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulses start (sampled at edge 0), then counts edges until done, optionally re-pulsing start at cycle repulse_at.
  task automatic run_sweep(input int repulse_at, output int n);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_after_start", {31'd0, done}, 32'd0);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == repulse_at);
      if (done) break;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_results(input string tag, input int e, input int p, input int fa, input int fb);
    chk({tag, "_err"},   32'(err_cnt), e);
    chk({tag, "_pass"},  {31'd0, pass}, p);
    chk({tag, "_faila"}, 32'(fail_a), fa);
    chk({tag, "_failb"}, 32'(fail_b), fb);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pass", {31'd0, pass}, 0);
    chk("rst_err",  32'(err_cnt), 0);
    chk("rst_a",    32'(a_out), 0);
    chk("rst_b",    32'(b_out), 0);
    @(negedge clk) rst_n = 1'b1;

`ifdef CMP_BIST_STOP_ON_FAIL_EN
    mode = 1;
    run_sweep(-1, cyc);
    chk("stop_cycles", cyc, 51);
    chk_results("stop", 1, 0, 1, 0);
    chk("stop_a_out", 32'(a_out), 1);
    chk("stop_b_out", 32'(b_out), 0);
`else
    mode = 0;
    run_sweep(-1, cyc);
    chk("healthy_cycles", cyc, 768);
    chk("healthy_done", {31'd0, done}, 1);
    chk_results("healthy", 0, 1, 0, 0);

    mode = 1;
    run_sweep(-1, cyc);
    chk("tied0_cycles", cyc, 768);
    chk_results("tied0", 120, 0, 1, 0);

    mode = 2;
    run_sweep(-1, cyc);
    chk_results("tied1", 136, 0, 0, 0);

    mode = 1;
    run_sweep(100, cyc);
    chk("repulse_cycles", cyc, 768);
    chk_results("repulse", 120, 0, 1, 0);

    mode = 0;
    run_sweep(-1, cyc);
    chk("restart_cycles", cyc, 768);
    chk_results("restart", 0, 1, 0, 0);

    mode = 3;
    run_sweep(-1, cyc);
    chk_results("single", 1, 0, 9, 3);
`endif

    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("midrst_busy",  {31'd0, busy}, 0);
    chk("midrst_done",  {31'd0, done}, 0);
    chk("midrst_pass",  {31'd0, pass}, 0);
    chk("midrst_err",   32'(err_cnt), 0);
    chk("midrst_faila", 32'(fail_a), 0);
    chk("midrst_a",     32'(a_out), 0);
    chk("midrst_b",     32'(b_out), 0);
    repeat (3) @(negedge clk);
    chk("midrst_idle_busy", {31'd0, busy}, 0);

    mode = 0;
    run_sweep(-1, cyc);
    chk("fresh_cycles", cyc, 768);
    chk_results("fresh", 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
